// File: rtl/irq_arbiter.sv
// irq_arbiter
//   Prioritised interrupt controller. It synchronises and edge-detects each
//   asynchronous event source and latches a pending flag and data word per
//   source. It grants one source at a time to the CPU through an
//   irq / ack (turnOffIRQ) handshake. Index 0 has the highest priority.
//
// Ports
//   clk          clock, all flops on posedge
//   rst          asynchronous, active-high reset
//   srcLevel     raw event levels; each rising edge is one event
//   srcData      per-source data, slice i = [i*DW +: DW], captured on event
//   enMask       per-source grant enable
//   globalEn     global interrupt enable
//   vecBase      vector table base address
//   ack          one-cycle acknowledge from the CPU
//   clrOverflow  pulse clearing all overflow flags
//   irq          interrupt request to the CPU
//   intData      data of the granted source
//   intAddr      vecBase + (intSrc << 1)
//   intSrc       granted source index
//   pending      registered pending flags
//   overflow     sticky flag: an event arrived while that source was still pending
module irq_arbiter #(
  parameter int NSRC        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DW          = 16,
  parameter int AW          = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSRC-1:0]          srcLevel,
  input  logic [NSRC*DW-1:0]       srcData,
  input  logic [NSRC-1:0]          enMask,
  input  logic                     globalEn,
  input  logic [AW-1:0]            vecBase,
  input  logic                     ack,
  input  logic                     clrOverflow,
  output logic                     irq,
  output logic [DW-1:0]            intData,
  output logic [AW-1:0]            intAddr,
  output logic [$clog2(NSRC)-1:0]  intSrc,
  output logic [NSRC-1:0]          pending,
  output logic [NSRC-1:0]          overflow
);

  localparam int IW = $clog2(NSRC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] evt;
  logic [NSRC-1:0] clr_vec;
  logic [NSRC-1:0] capture;
  logic [NSRC-1:0] ovf_set;
  logic [NSRC-1:0] cand;
  logic [DW-1:0]   data_q [NSRC];
  logic [IW-1:0]   grant_idx;
  logic            grant_vld;
  logic            load;

  // Synchroniser chain and edge history; both start at zero, so a level that
  // is already high when reset is released counts as one event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= srcLevel;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Pending bit retired by the acknowledge of the current grant.
  always_comb begin
    clr_vec = '0;
    if (state_q == S_ASSERT && ack) clr_vec[intSrc] = 1'b1;
  end

  // An event on the source being acknowledged re-arms it (set wins) and is
  // not an overflow.
  assign capture = evt & (~pending | clr_vec);
  assign ovf_set = evt & pending & ~clr_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= (pending & ~clr_vec) | evt;
      overflow <= clrOverflow ? ovf_set : (overflow | ovf_set);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (capture[i]) data_q[i] <= srcData[i*DW +: DW];
    end
  end

  // Lowest-index enabled pending source wins; only registered pending is used.
  assign cand = pending & enMask;

  always_comb begin
    grant_vld = globalEn && (cand != '0);
    grant_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) grant_idx = IW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          state_d = S_ASSERT;
          load    = 1'b1;
        end
      end
      S_ASSERT: begin
        if (ack) state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // irq is decoded straight from the state so reset drops it asynchronously.
  assign irq = (state_q == S_ASSERT);

  // Grant outputs hold their value until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intSrc  <= '0;
      intData <= '0;
      intAddr <= '0;
    end else if (load) begin
      intSrc  <= grant_idx;
      intData <= data_q[grant_idx];
      intAddr <= vecBase + {{(AW-IW-1){1'b0}}, grant_idx, 1'b0};
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter
//   Self-checking bench for irq_arbiter. A behavioural model advances once per
//   clock and every output is compared against it on each falling edge. Directed
//   scenarios with literal expectations come first, followed by a randomized
//   phase.
module tb_irq_arbiter;

  localparam int NSRC = 4;
  localparam int S    = 2;
  localparam int DW   = 16;
  localparam int AW   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [NSRC-1:0]    srcLevel;
  logic [NSRC*DW-1:0] srcData;
  logic [NSRC-1:0]    enMask;
  logic               globalEn;
  logic [AW-1:0]      vecBase;
  logic               ack;
  logic               clrOverflow;
  logic               irq;
  logic [DW-1:0]      intData;
  logic [AW-1:0]      intAddr;
  logic [1:0]         intSrc;
  logic [NSRC-1:0]    pending;
  logic [NSRC-1:0]    overflow;

  int n_checks = 0;
  int n_fail   = 0;

  irq_arbiter #(.NSRC(NSRC), .SYNC_STAGES(S), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .srcLevel(srcLevel), .srcData(srcData),
    .enMask(enMask), .globalEn(globalEn), .vecBase(vecBase), .ack(ack),
    .clrOverflow(clrOverflow), .irq(irq), .intData(intData),
    .intAddr(intAddr), .intSrc(intSrc), .pending(pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: hist[j] is the level sampled j+1 edges ago, so an event
  // at this edge is a 0->1 step seen S edges back.
  typedef struct packed {
    logic [S:0][NSRC-1:0]    hist;
    logic [NSRC-1:0]         pend;
    logic [NSRC-1:0]         ovf;
    logic [NSRC-1:0][DW-1:0] data;
    logic                    busy;   // irq asserted
    logic                    gap;    // cool-down cycle after an ack
    logic [1:0]              src;
    logic [DW-1:0]           idata;
    logic [AW-1:0]           iaddr;
  } model_t;

  model_t m;

  function automatic model_t step(input model_t c);
    model_t          n;
    logic [NSRC-1:0] ev;
    logic [NSRC-1:0] ovs;
    logic [NSRC-1:0] cnd;
    logic            acked;
    n     = c;
    ev    = c.hist[S-1] & ~c.hist[S];
    acked = c.busy && ack;
    cnd   = c.pend & enMask;
    // grant / handshake, using values from before this edge
    if (c.busy) begin
      if (ack) begin
        n.busy = 1'b0;
        n.gap  = 1'b1;
      end
    end else if (c.gap) begin
      n.gap = 1'b0;
    end else if (globalEn && cnd != 0) begin
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (cnd[i]) n.src = 2'(i);
      end
      n.busy  = 1'b1;
      n.idata = c.data[n.src];
      n.iaddr = vecBase + 32'(n.src) * 2;
    end
    // events
    ovs = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (ev[i]) begin
        if (!c.pend[i] || (acked && c.src == 2'(i))) begin
          n.pend[i] = 1'b1;
          n.data[i] = srcData[i*DW +: DW];
        end else begin
          ovs[i] = 1'b1;
        end
      end else if (acked && c.src == 2'(i)) begin
        n.pend[i] = 1'b0;
      end
    end
    n.ovf = clrOverflow ? ovs : (c.ovf | ovs);
    for (int j = S; j >= 1; j--) n.hist[j] = c.hist[j-1];
    n.hist[0] = srcLevel;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= step(m);
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_irq",      64'(irq),      64'(m.busy));
      chk("m_pending",  64'(pending),  64'(m.pend));
      chk("m_overflow", 64'(overflow), 64'(m.ovf));
      chk("m_intSrc",   64'(intSrc),   64'(m.src));
      chk("m_intData",  64'(intData),  64'(m.idata));
      chk("m_intAddr",  64'(intAddr),  64'(m.iaddr));
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; srcLevel = '0; srcData = '0; enMask = 4'hF; globalEn = 1'b1;
    vecBase = 32'h100; ack = 1'b0; clrOverflow = 1'b0;
    tick(2);
    #3 rst = 1'b0;
    tick(1);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_intAddr", 64'(intAddr), 64'd0);

    // T1: single event on source 1
    srcData[1*DW +: DW] = 16'h0041; srcLevel[1] = 1'b1;
    tick(3);
    chk("t1_pending_early", 64'(pending), 64'h2);
    chk("t1_irq_early", 64'(irq), 64'd0);
    tick(1);
    chk("t1_irq", 64'(irq), 64'd1);
    chk("t1_intData", 64'(intData), 64'h0041);
    chk("t1_intAddr", 64'(intAddr), 64'h102);
    chk("t1_intSrc", 64'(intSrc), 64'd1);
    pulse_ack();
    chk("t1_irq_ack", 64'(irq), 64'd0);
    chk("t1_pending_ack", 64'(pending), 64'd0);
    srcLevel[1] = 1'b0; tick(4);

    // T2: simultaneous events on 0 and 2
    srcData[0 +: DW] = 16'h0A0A; srcData[2*DW +: DW] = 16'h0C0C;
    srcLevel[0] = 1'b1; srcLevel[2] = 1'b1;
    tick(4);
    chk("t2_src0", 64'(intSrc), 64'd0);
    chk("t2_addr0", 64'(intAddr), 64'h100);
    pulse_ack();
    chk("t2_gap_irq", 64'(irq), 64'd0);
    chk("t2_gap_pending", 64'(pending), 64'h4);
    tick(1);
    chk("t2_idle_irq", 64'(irq), 64'd0);
    tick(1);
    chk("t2_irq2", 64'(irq), 64'd1);
    chk("t2_src2", 64'(intSrc), 64'd2);
    chk("t2_addr2", 64'(intAddr), 64'h104);
    chk("t2_data2", 64'(intData), 64'h0C0C);
    pulse_ack();
    srcLevel[0] = 1'b0; srcLevel[2] = 1'b0; tick(4);

    // T3: globally disabled, then enabled
    globalEn = 1'b0; srcData[3*DW +: DW] = 16'h0D0D; srcLevel[3] = 1'b1;
    tick(4);
    chk("t3_pending", 64'(pending), 64'h8);
    chk("t3_irq_off", 64'(irq), 64'd0);
    globalEn = 1'b1;
    tick(1);
    chk("t3_irq_on", 64'(irq), 64'd1);
    chk("t3_addr", 64'(intAddr), 64'h106);
    pulse_ack();
    srcLevel[3] = 1'b0; tick(4);

    // T4: overflow while pending, then cleared
    srcData[1*DW +: DW] = 16'h1111; srcLevel[1] = 1'b1;
    tick(4);
    chk("t4_data1", 64'(intData), 64'h1111);
    srcLevel[1] = 1'b0; tick(1);
    srcData[1*DW +: DW] = 16'h2222; srcLevel[1] = 1'b1;
    tick(3);
    chk("t4_overflow", 64'(overflow), 64'h2);
    chk("t4_data_kept", 64'(intData), 64'h1111);
    clrOverflow = 1'b1; tick(1); clrOverflow = 1'b0;
    chk("t4_ovf_clr", 64'(overflow), 64'h0);
    pulse_ack();
    srcLevel[1] = 1'b0; tick(4);

    // T5: event on the granted source in the ack cycle
    srcData[2*DW +: DW] = 16'h0005; srcLevel[2] = 1'b1;
    tick(4);
    chk("t5_src", 64'(intSrc), 64'd2);
    srcLevel[2] = 1'b0; tick(2);
    srcData[2*DW +: DW] = 16'h0055; srcLevel[2] = 1'b1;
    tick(2);
    pulse_ack();
    chk("t5_irq", 64'(irq), 64'd0);
    chk("t5_pending", 64'(pending), 64'h4);
    chk("t5_overflow", 64'(overflow), 64'h0);
    tick(2);
    chk("t5_regrant", 64'(irq), 64'd1);
    chk("t5_newdata", 64'(intData), 64'h0055);
    pulse_ack();
    srcLevel[2] = 1'b0; tick(4);

    // T6: reset during a grant, then a stray ack
    srcData[0 +: DW] = 16'h0E0E; srcLevel[0] = 1'b1;
    tick(4);
    chk("t6_irq_before", 64'(irq), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("t6_irq_async", 64'(irq), 64'd0);
    chk("t6_pending", 64'(pending), 64'd0);
    srcLevel[0] = 1'b0;
    tick(1);
    rst = 1'b0;
    pulse_ack();
    chk("t6_ack_idle_irq", 64'(irq), 64'd0);
    chk("t6_ack_idle_pend", 64'(pending), 64'd0);
    tick(2);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NSRC; i++) begin
        if ($urandom_range(0, 7) == 0) srcLevel[i] = ~srcLevel[i];
      end
      srcData = {$urandom, $urandom};
      ack = irq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      clrOverflow = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) enMask = 4'($urandom);
      if ($urandom_range(0, 49) == 0) globalEn = ~globalEn;
      if ($urandom_range(0, 63) == 0) vecBase = $urandom;
      tick(1);
    end
    ack = 1'b0; clrOverflow = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
